// File: rtl/vga_pattern_gen.sv
// VGA timing generator with selectable test patterns.
// Counters drive registered sync, data-enable and colour outputs.
module vga_pattern_gen #(
  parameter int HOR_ACT   = 640,
  parameter int HOR_FP    = 16,
  parameter int HOR_SYNC  = 96,
  parameter int HOR_BP    = 48,
  parameter int VERT_ACT  = 480,
  parameter int VERT_FP   = 11,
  parameter int VERT_SYNC = 2,
  parameter int VERT_BP   = 31,
  parameter int SYNC_POL  = 0
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start
);

  localparam int HTOT = HOR_ACT + HOR_FP + HOR_SYNC + HOR_BP;
  localparam int VTOT = VERT_ACT + VERT_FP + VERT_SYNC + VERT_BP;

  localparam logic [10:0] H_LAST = 11'(HTOT - 1);
  localparam logic [10:0] V_LAST = 11'(VTOT - 1);
  localparam logic [10:0] H_ACT  = 11'(HOR_ACT);
  localparam logic [10:0] V_ACT  = 11'(VERT_ACT);
  localparam logic [10:0] H_SS   = 11'(HOR_ACT + HOR_FP);
  localparam logic [10:0] H_SE   = 11'(HOR_ACT + HOR_FP + HOR_SYNC);
  localparam logic [10:0] V_SS   = 11'(VERT_ACT + VERT_FP);
  localparam logic [10:0] V_SE   = 11'(VERT_ACT + VERT_FP + VERT_SYNC);
  localparam logic [10:0] BAR_W  = 11'(HOR_ACT / 8);

  localparam logic SYNC_ON  = SYNC_POL[0];
  localparam logic SYNC_OFF = ~SYNC_ON;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [1:0]  pat_q, pat_d;
  logic [23:0] solid_q, solid_d;

  logic [23:0] rgb_q, rgb_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        de_q, de_d;
  logic        fs_q, fs_d;

  logic        h_end;
  logic        v_end;
  logic        in_h_act;
  logic        in_v_act;
  logic        in_hs;
  logic        in_vs;
  logic [10:0] bar;
  logic [23:0] pix;

  assign h_end    = (h_cnt_q == H_LAST);
  assign v_end    = (v_cnt_q == V_LAST);
  assign in_h_act = (h_cnt_q < H_ACT);
  assign in_v_act = (v_cnt_q < V_ACT);
  assign in_hs    = (h_cnt_q >= H_SS) && (h_cnt_q < H_SE);
  assign in_vs    = (v_cnt_q >= V_SS) && (v_cnt_q < V_SE);
  assign bar      = h_cnt_q / BAR_W;

  // Run control, raster counters and per-frame latching of pattern inputs
  always_comb begin
    state_d     = state_q;
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    frame_cnt_d = frame_cnt_q;
    pat_d       = pat_q;
    solid_d     = solid_q;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = RUN;
          h_cnt_d = 11'd0;
          v_cnt_d = 11'd0;
          pat_d   = pattern_sel;
          solid_d = solid_rgb;
        end
      end
      RUN: begin
        if (h_end) begin
          h_cnt_d = 11'd0;
          v_cnt_d = v_end ? 11'd0 : v_cnt_q + 11'd1;
        end else begin
          h_cnt_d = h_cnt_q + 11'd1;
        end
        if (h_end && v_end) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          pat_d       = pattern_sel;
          solid_d     = solid_rgb;
          if (!en) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pattern colour for the current raster position
  always_comb begin
    pix = 24'h000000;
    unique case (pat_q)
      2'd0: begin
        unique case (bar)
          11'd0:   pix = 24'hFFFFFF;
          11'd1:   pix = 24'hFFFF00;
          11'd2:   pix = 24'h00FFFF;
          11'd3:   pix = 24'h00FF00;
          11'd4:   pix = 24'hFF00FF;
          11'd5:   pix = 24'hFF0000;
          11'd6:   pix = 24'h0000FF;
          default: pix = 24'h000000;
        endcase
      end
      2'd1: begin
        pix = (h_cnt_q[5] ^ v_cnt_q[5]) ? 24'h000000 : 24'hFFFFFF;
      end
      2'd2: begin
        pix = {h_cnt_q[7:0], v_cnt_q[7:0], frame_cnt_q};
      end
      default: begin
        pix = solid_q;
      end
    endcase
  end

  // Output stage: one cycle behind the counters, idle values outside RUN
  always_comb begin
    rgb_d   = 24'h000000;
    hsync_d = SYNC_OFF;
    vsync_d = SYNC_OFF;
    de_d    = 1'b0;
    fs_d    = 1'b0;
    if (state_q == RUN) begin
      de_d    = in_h_act && in_v_act;
      rgb_d   = de_d ? pix : 24'h000000;
      hsync_d = in_hs ? SYNC_ON : SYNC_OFF;
      vsync_d = in_vs ? SYNC_ON : SYNC_OFF;
      fs_d    = (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      h_cnt_q     <= 11'd0;
      v_cnt_q     <= 11'd0;
      frame_cnt_q <= 8'd0;
      pat_q       <= 2'd0;
      solid_q     <= 24'h000000;
      rgb_q       <= 24'h000000;
      hsync_q     <= SYNC_OFF;
      vsync_q     <= SYNC_OFF;
      de_q        <= 1'b0;
      fs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      pat_q       <= pat_d;
      solid_q     <= solid_d;
      rgb_q       <= rgb_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
      fs_q        <= fs_d;
    end
  end

  assign r           = rgb_q[23:16];
  assign g           = rgb_q[15:8];
  assign b           = rgb_q[7:0];
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen on a reduced raster (104x82 total).
// Reference model works from linear pixel index within the frame.
module tb_vga_pattern_gen;

  localparam int HA = 84;
  localparam int HF = 4;
  localparam int HS = 8;
  localparam int HB = 8;
  localparam int VA = 72;
  localparam int VF = 3;
  localparam int VS = 2;
  localparam int VB = 5;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;

  localparam logic [27:0] IDLE_V = {24'h000000, 1'b1, 1'b1, 1'b0, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [23:0] solid_rgb = 24'h0;
  logic [7:0]  r, g, b;
  logic        hsync, vsync, de, frame_start;
  logic [27:0] obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_pattern_gen #(
    .HOR_ACT(HA), .HOR_FP(HF), .HOR_SYNC(HS), .HOR_BP(HB),
    .VERT_ACT(VA), .VERT_FP(VF), .VERT_SYNC(VS), .VERT_BP(VB),
    .SYNC_POL(0)
  ) dut (
    .pixel_clk(clk), .rst_n(rst_n), .en(en),
    .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .r(r), .g(g), .b(b),
    .hsync(hsync), .vsync(vsync), .de(de),
    .frame_start(frame_start)
  );

  assign obs = {r, g, b, hsync, vsync, de, frame_start};

  function automatic logic [23:0] bar_col(int k);
    case (k)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [27:0] ref_pix(int p, logic [1:0] pat,
                                          logic [23:0] sol, logic [7:0] fc);
    int x, y;
    logic d, h, v;
    logic [23:0] c;
    x = p % HT;
    y = p / HT;
    d = (x < HA) && (y < VA);
    h = !((x >= HA + HF) && (x < HA + HF + HS));
    v = !((y >= VA + VF) && (y < VA + VF + VS));
    c = 24'h0;
    if (d) begin
      case (pat)
        2'd0: c = bar_col(x / (HA / 8));
        2'd1: c = (((x / 32) % 2) == ((y / 32) % 2)) ? 24'hFFFFFF : 24'h0;
        2'd2: c = {8'(x % 256), 8'(y % 256), fc};
        default: c = sol;
      endcase
    end
    return {c, h, v, d, (p == 0)};
  endfunction

  // Reference model: expected outputs after each rising edge
  bit          m_run = 1'b0;
  int          m_p = 0;
  logic [7:0]  m_fc = 8'd0;
  logic [1:0]  m_pat = 2'd0;
  logic [23:0] m_sol = 24'h0;
  logic [27:0] exp_v = IDLE_V;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_run <= 1'b0;
      m_p   <= 0;
      m_fc  <= 8'd0;
      m_pat <= 2'd0;
      m_sol <= 24'h0;
      exp_v <= IDLE_V;
    end else if (!m_run) begin
      exp_v <= IDLE_V;
      if (en) begin
        m_run <= 1'b1;
        m_p   <= 0;
        m_pat <= pattern_sel;
        m_sol <= solid_rgb;
      end
    end else begin
      exp_v <= ref_pix(m_p, m_pat, m_sol, m_fc);
      if (m_p == FR - 1) begin
        m_p   <= 0;
        m_fc  <= m_fc + 8'd1;
        m_pat <= pattern_sel;
        m_sol <= solid_rgb;
        if (!en) m_run <= 1'b0;
      end else begin
        m_p <= m_p + 1;
      end
    end
  end

  task automatic test_reset();
    int bad;
    logic [27:0] fo, fe;
    bad = 0;
    fo = '0;
    fe = '0;
    rst_n = 1'b0;
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({hsync, vsync, de, frame_start, r, g, b} !== {4'b1100, 24'h0}) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: got hs=%b vs=%b de=%b fs=%b rgb=%h want hs=1 vs=1 de=0 fs=0 rgb=000000",
                 i, hsync, vsync, de, frame_start, {r, g, b});
      end
      if (obs !== exp_v) begin
        if (bad == 0) begin fo = obs; fe = exp_v; end
        bad++;
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reset_model: %0d bad cycles, first got %h want %h", bad, fo, fe);
    end
  endtask

  task automatic test_timing();
    int bad, hs_first, hs_len, de_rise, vs_first, vs_len, de_cnt, fs_next;
    logic prev_de;
    logic [27:0] fo, fe;
    logic [23:0] line0 [HA];
    int xs [7];
    logic [23:0] cs [7];
    bad = 0; hs_first = -1; hs_len = 0; de_rise = -1;
    vs_first = -1; vs_len = 0; de_cnt = 0; fs_next = -1;
    fo = '0; fe = '0;
    pattern_sel = 2'd0;
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b0 || de !== 1'b0) begin
      errors++;
      $display("FAIL start_edge_k: got fs=%b de=%b want fs=0 de=0", frame_start, de);
    end
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1 || de !== 1'b1) begin
      errors++;
      $display("FAIL start_edge_k1: got fs=%b de=%b want fs=1 de=1", frame_start, de);
    end
    prev_de = 1'b1;
    for (int i = 0; i <= FR; i++) begin
      if (i > 0) @(negedge clk);
      if (obs !== exp_v) begin
        if (bad == 0) begin fo = obs; fe = exp_v; end
        bad++;
      end
      if (i < HT && !hsync) begin
        if (hs_first < 0) hs_first = i;
        hs_len++;
      end
      if (i > 0 && de && !prev_de && de_rise < 0) de_rise = i;
      prev_de = de;
      if (i < FR && !vsync) begin
        if (vs_first < 0) vs_first = i;
        vs_len++;
      end
      if (i < FR && de) de_cnt++;
      if (i > 0 && frame_start && fs_next < 0) fs_next = i;
      if (i < HA) line0[i] = {r, g, b};
    end
    checks++;
    if (hs_first !== HA + HF) begin
      errors++;
      $display("FAIL hsync_start: got %0d want %0d", hs_first, HA + HF);
    end
    checks++;
    if (hs_len !== HS) begin
      errors++;
      $display("FAIL hsync_len: got %0d want %0d", hs_len, HS);
    end
    checks++;
    if (de_rise !== HT) begin
      errors++;
      $display("FAIL line_period: got %0d want %0d", de_rise, HT);
    end
    checks++;
    if (vs_first !== (VA + VF) * HT) begin
      errors++;
      $display("FAIL vsync_start: got %0d want %0d", vs_first, (VA + VF) * HT);
    end
    checks++;
    if (vs_len !== VS * HT) begin
      errors++;
      $display("FAIL vsync_len: got %0d want %0d", vs_len, VS * HT);
    end
    checks++;
    if (de_cnt !== HA * VA) begin
      errors++;
      $display("FAIL de_count: got %0d want %0d", de_cnt, HA * VA);
    end
    checks++;
    if (fs_next !== FR) begin
      errors++;
      $display("FAIL frame_period: got %0d want %0d", fs_next, FR);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL timing_model: %0d bad cycles, first got %h want %h", bad, fo, fe);
    end
    xs = '{0, 9, 10, 69, 70, 79, 83};
    cs = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h0000FF,
           24'h000000, 24'h000000, 24'h000000};
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (line0[xs[k]] !== cs[k]) begin
        errors++;
        $display("FAIL bars_x%0d: got %h want %h", xs[k], line0[xs[k]], cs[k]);
      end
    end
  endtask

  task automatic test_pattern_switch();
    int bad;
    logic fs_end;
    logic [27:0] fo, fe;
    logic [23:0] c20a, c20b, c00, c32_0, c32_32, c64_32;
    bad = 0; fo = '0; fe = '0;
    c20a = '0; c20b = '0; c32_0 = '0; c32_32 = '0; c64_32 = '0;
    for (int i = 1; i <= FR; i++) begin
      @(negedge clk);
      if (obs !== exp_v) begin
        if (bad == 0) begin fo = obs; fe = exp_v; end
        bad++;
      end
      if (i == 10 * HT) pattern_sel = 2'd1;
      if (i == 20 * HT) c20a = {r, g, b};
      if (i == 20 * HT + 10) c20b = {r, g, b};
    end
    fs_end = frame_start;
    c00 = {r, g, b};
    for (int j = 1; j <= 32 * HT + 64; j++) begin
      @(negedge clk);
      if (obs !== exp_v) begin
        if (bad == 0) begin fo = obs; fe = exp_v; end
        bad++;
      end
      if (j == 32) c32_0 = {r, g, b};
      if (j == 32 * HT + 32) c32_32 = {r, g, b};
      if (j == 32 * HT + 64) c64_32 = {r, g, b};
    end
    checks++;
    if (c20a !== 24'hFFFFFF || c20b !== 24'hFFFF00) begin
      errors++;
      $display("FAIL bars_persist: got %h %h want FFFFFF FFFF00", c20a, c20b);
    end
    checks++;
    if (fs_end !== 1'b1) begin
      errors++;
      $display("FAIL switch_fs: got %b want 1", fs_end);
    end
    checks++;
    if (c00 !== 24'hFFFFFF || c32_0 !== 24'h000000) begin
      errors++;
      $display("FAIL checker_row0: got %h %h want FFFFFF 000000", c00, c32_0);
    end
    checks++;
    if (c32_32 !== 24'hFFFFFF || c64_32 !== 24'h000000) begin
      errors++;
      $display("FAIL checker_row32: got %h %h want FFFFFF 000000", c32_32, c64_32);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL switch_model: %0d bad cycles, first got %h want %h", bad, fo, fe);
    end
  endtask

  task automatic test_stop_restart();
    int bad, n, fs_cnt, idle_bad, fs_at;
    logic fs4, hs_last;
    logic [23:0] c10, c53;
    logic [27:0] fo, fe;
    bad = 0; fs_cnt = 0; idle_bad = 0; fs_at = -1;
    fo = '0; fe = '0; c10 = '0; c53 = '0; hs_last = 1'b1;
    pattern_sel = 2'd2;
    n = FR - (32 * HT + 64);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (obs !== exp_v) begin
        if (bad == 0) begin fo = obs; fe = exp_v; end
        bad++;
      end
    end
    fs4 = frame_start;
    for (int i = 1; i <= FR + 300; i++) begin
      @(negedge clk);
      if (obs !== exp_v) begin
        if (bad == 0) begin fo = obs; fe = exp_v; end
        bad++;
      end
      if (i == 1) c10 = {r, g, b};
      if (i == 10 * HT) en = 1'b0;
      if (i == (VT - 1) * HT + HA + HF) hs_last = hsync;
      if (frame_start) fs_cnt++;
      if (i >= FR && obs !== IDLE_V) idle_bad++;
    end
    checks++;
    if (fs4 !== 1'b1) begin
      errors++;
      $display("FAIL stop_fs4: got %b want 1", fs4);
    end
    checks++;
    if (c10 !== {8'd1, 8'd0, 8'd3}) begin
      errors++;
      $display("FAIL grad_f3: got %h want 010003", c10);
    end
    checks++;
    if (hs_last !== 1'b0) begin
      errors++;
      $display("FAIL last_line_hsync: got %b want 0", hs_last);
    end
    checks++;
    if (fs_cnt !== 0 || idle_bad !== 0) begin
      errors++;
      $display("FAIL stop_idle: got fs=%0d idle_bad=%0d want 0 0", fs_cnt, idle_bad);
    end
    en = 1'b1;
    for (int i = 1; i <= 4 && fs_at < 0; i++) begin
      @(negedge clk);
      if (frame_start) fs_at = i;
    end
    checks++;
    if (fs_at !== 2) begin
      errors++;
      $display("FAIL restart_latency: got %0d want 2", fs_at);
    end
    for (int i = 1; i <= 3 * HT + 5; i++) begin
      @(negedge clk);
      if (obs !== exp_v) begin
        if (bad == 0) begin fo = obs; fe = exp_v; end
        bad++;
      end
    end
    c53 = {r, g, b};
    checks++;
    if (c53 !== {8'd5, 8'd3, 8'd4}) begin
      errors++;
      $display("FAIL grad_continue: got %h want 050304", c53);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL stop_model: %0d bad cycles, first got %h want %h", bad, fo, fe);
    end
  endtask

  task automatic test_random();
    int bad, drop, up, p0, fs_cnt, fs1, fs2;
    logic [27:0] fo, fe;
    bad = 0; fs_cnt = 0; fs1 = -1; fs2 = -1;
    fo = '0; fe = '0;
    p0 = 3 * HT + 5;
    pattern_sel = 2'd3;
    solid_rgb = 24'($urandom);
    drop = int'($urandom_range(40 * HT, 5 * HT));
    up = drop + int'($urandom_range(30 * HT, HT));
    for (int i = 1; i <= 2 * FR; i++) begin
      @(negedge clk);
      if (obs !== exp_v) begin
        if (bad == 0) begin fo = obs; fe = exp_v; end
        bad++;
      end
      if (frame_start) begin
        fs_cnt++;
        if (fs1 < 0) fs1 = i;
        else if (fs2 < 0) fs2 = i;
      end
      if (i == drop) en = 1'b0;
      if (i == up) en = 1'b1;
      if ($urandom_range(999, 0) == 0) begin
        pattern_sel = 2'($urandom);
        solid_rgb = 24'($urandom);
      end
    end
    checks++;
    if (fs_cnt !== 2 || fs1 !== FR - p0 || fs2 !== 2 * FR - p0) begin
      errors++;
      $display("FAIL no_gap: got n=%0d at %0d,%0d want n=2 at %0d,%0d",
               fs_cnt, fs1, fs2, FR - p0, 2 * FR - p0);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL random_model: %0d bad cycles, first got %h want %h", bad, fo, fe);
    end
  endtask

  task automatic test_reset_mid();
    int bad, hs_at, fs_at;
    logic [27:0] fo, fe;
    bad = 0; hs_at = -1; fs_at = -1;
    fo = '0; fe = '0;
    en = 1'b1;
    pattern_sel = 2'd2;
    for (int i = 0; i <= HT && hs_at < 0; i++) begin
      @(negedge clk);
      if (!hsync) hs_at = i;
    end
    checks++;
    if (hs_at < 0) begin
      errors++;
      $display("FAIL find_hsync: got none within %0d want a low cycle", HT);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL mid_reset: got %h want %h", obs, IDLE_V);
    end
    for (int i = 1; i <= 4 && fs_at < 0; i++) begin
      @(negedge clk);
      if (frame_start) fs_at = i;
    end
    checks++;
    if (fs_at !== 2) begin
      errors++;
      $display("FAIL reset_restart: got %0d want 2", fs_at);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({r, g, b} !== {8'd2, 8'd0, 8'd0}) begin
      errors++;
      $display("FAIL reset_frame_cnt: got %h want 020000", {r, g, b});
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (obs !== exp_v) begin
        if (bad == 0) begin fo = obs; fe = exp_v; end
        bad++;
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reset_model: %0d bad cycles, first got %h want %h", bad, fo, fe);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_timing();
    test_pattern_switch();
    test_stop_restart();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
